// File: rtl/subckt_mon_pkg.sv
// Shared types and sizing helpers for the sub-circuit switching-activity monitor.
package subckt_mon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    COUNT  = 2'd2,
    REPORT = 2'd3
  } state_t;

  // Window length used when a measurement is started with win_len == 0.
  localparam int unsigned DEF_WIN_LEN = 1;

  // Total input-toggle width: CNT_W transitions, each adding up to IN_W toggles.
  function automatic int unsigned in_tog_w(input int unsigned in_w, input int unsigned cnt_w);
    return cnt_w + $clog2(in_w + 1);
  endfunction

endpackage

// File: rtl/subckt_toggle_popcount.sv
// Combinational toggle counter: number of differing bits between two IN_W-bit vectors.
module subckt_toggle_popcount #(
  parameter int unsigned IN_W = 4
) (
  input  logic [IN_W-1:0]            cur,
  input  logic [IN_W-1:0]            prev,
  output logic [$clog2(IN_W+1)-1:0]  cnt_c
);

  localparam int unsigned PC_W = $clog2(IN_W + 1);

  logic [IN_W-1:0] diff;

  assign diff = cur ^ prev;

  always_comb begin
    cnt_c = '0;
    for (int i = 0; i < int'(IN_W); i++) begin
      cnt_c = cnt_c + PC_W'(diff[i]);
    end
  end

endmodule

// File: rtl/subckt_activity_monitor.sv
// Windowed input/output toggle counter for power-experiment sub-circuits.
// Optional per-input toggle counters enabled by SUBCKT_MON_PER_INPUT_EN.
module subckt_activity_monitor
  import subckt_mon_pkg::*;
#(
  parameter int unsigned IN_W  = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [CNT_W-1:0]                   win_len,
  input  logic                               smp_valid,
  input  logic [IN_W-1:0]                    smp_in,
  input  logic                               smp_out,
  output logic                               busy,
  output logic                               res_valid,
  input  logic                               res_ready,
  output logic [in_tog_w(IN_W, CNT_W)-1:0]   res_in_tog,
  output logic [CNT_W-1:0]                   res_out_tog
`ifdef SUBCKT_MON_PER_INPUT_EN
  ,
  output logic [IN_W*CNT_W-1:0]              res_in_tog_each
`endif
);

  localparam int unsigned IT_W = in_tog_w(IN_W, CNT_W);
  localparam int unsigned PC_W = $clog2(IN_W + 1);

  state_t            state_q;
  state_t            state_d;
  logic              accept_start;
  logic              prime_en;
  logic              count_en;
  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  tcnt_q;
  logic [CNT_W-1:0]  tcnt_inc;
  logic [IN_W-1:0]   prev_in_q;
  logic              prev_out_q;
  logic [PC_W-1:0]   in_pc_c;

  subckt_toggle_popcount #(
    .IN_W (IN_W)
  ) u_popcount (
    .cur   (smp_in),
    .prev  (prev_in_q),
    .cnt_c (in_pc_c)
  );

  // Next-state and datapath strobes.
  always_comb begin
    state_d      = state_q;
    accept_start = 1'b0;
    prime_en     = 1'b0;
    count_en     = 1'b0;
    tcnt_inc     = tcnt_q + CNT_W'(1);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          accept_start = 1'b1;
          state_d      = PRIME;
        end
      end
      PRIME: begin
        if (smp_valid) begin
          prime_en = 1'b1;
          state_d  = COUNT;
        end
      end
      COUNT: begin
        if (smp_valid) begin
          count_en = 1'b1;
          if (tcnt_inc == len_q) begin
            state_d = REPORT;
          end
        end
      end
      REPORT: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with status flags registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      busy      <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy      <= (state_d != IDLE);
      res_valid <= (state_d == REPORT);
    end
  end

  // Window length, reference sample and totals; held outside PRIME/COUNT updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q       <= '0;
      tcnt_q      <= '0;
      prev_in_q   <= '0;
      prev_out_q  <= 1'b0;
      res_in_tog  <= '0;
      res_out_tog <= '0;
    end else if (accept_start) begin
      len_q       <= (win_len == '0) ? CNT_W'(DEF_WIN_LEN) : win_len;
      tcnt_q      <= '0;
      res_in_tog  <= '0;
      res_out_tog <= '0;
    end else begin
      if (prime_en || count_en) begin
        prev_in_q  <= smp_in;
        prev_out_q <= smp_out;
      end
      if (count_en) begin
        tcnt_q      <= tcnt_inc;
        res_in_tog  <= res_in_tog + IT_W'(in_pc_c);
        res_out_tog <= res_out_tog + CNT_W'(smp_out ^ prev_out_q);
      end
    end
  end

`ifdef SUBCKT_MON_PER_INPUT_EN
  logic [IN_W-1:0] bit_tog;

  assign bit_tog = smp_in ^ prev_in_q;

  // Per-input counters follow the same clear/hold rules as the totals.
  always_ff @(posedge clk) begin
    if (rst || accept_start) begin
      res_in_tog_each <= '0;
    end else if (count_en) begin
      for (int i = 0; i < int'(IN_W); i++) begin
        res_in_tog_each[i*CNT_W +: CNT_W] <= res_in_tog_each[i*CNT_W +: CNT_W] + CNT_W'(bit_tog[i]);
      end
    end
  end
`endif

endmodule
